// File: rtl/out_channel_checker.sv
// rtl/out_channel_checker.sv - captures program output words and checks them against a host-loaded table
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 100,
  parameter int NExpected          = 2,
  localparam int W  = MemoryElementWidth,
  localparam int AW = $clog2(NOut),
  localparam int CW = $clog2(NOut + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          expWrite,
  input  logic [AW-1:0] expAddr,
  input  logic [W-1:0]  expData,
  input  logic          outValid,
  input  logic [W-1:0]  outData,
  output logic          outReady,
  input  logic          programFinished,
  output logic          finished,
  output logic          success,
  output logic [CW-1:0] outCount,
  output logic [AW-1:0] mismatchIndex,
  output logic          overflow
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] CHECK   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]    r_state;
  logic          r_out_ready;
  logic          r_finished;
  logic          r_success;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_mismatch;
  logic          r_overflow;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_idx;
  logic [W-1:0]  r_buf [NOut];
  logic [W-1:0]  r_exp [NOut];

  logic          w_accept;
  logic          w_count_bad;
  logic [AW-1:0] w_short_index;
  logic [AW-1:0] w_wr_ptr_next;

  // start wins over a word presented in the same cycle, so that word is dropped
  assign w_accept      = (r_state == COLLECT) && outValid && !start;
  assign w_count_bad   = r_overflow || (r_count != CW'(NExpected));
  assign w_short_index = (r_count < CW'(NExpected)) ? AW'(r_count) : AW'(NExpected - 1);
  assign w_wr_ptr_next = (r_wr_ptr == AW'(NOut - 1)) ? '0 : r_wr_ptr + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_ready <= 1'b0;
      r_finished  <= 1'b0;
      r_success   <= 1'b0;
      r_count     <= '0;
      r_mismatch  <= '0;
      r_overflow  <= 1'b0;
      r_wr_ptr    <= '0;
      r_idx       <= '0;
    end else if (start) begin
      r_state     <= COLLECT;
      r_out_ready <= 1'b1;
      r_finished  <= 1'b0;
      r_success   <= 1'b0;
      r_count     <= '0;
      r_mismatch  <= '0;
      r_overflow  <= 1'b0;
      r_wr_ptr    <= '0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        IDLE: ;
        COLLECT: begin
          if (w_accept) begin
            r_wr_ptr <= w_wr_ptr_next;
            if (r_count == CW'(NOut)) r_overflow <= 1'b1;
            else                      r_count    <= r_count + 1'b1;
          end
          if (programFinished) begin
            r_state     <= CHECK;
            r_out_ready <= 1'b0;
            r_idx       <= '0;
          end
        end
        CHECK: begin
          // the first CHECK cycle screens the count and also compares index 0
          if (r_idx == '0 && w_count_bad) begin
            r_success  <= 1'b0;
            r_mismatch <= w_short_index;
            r_state    <= DONE;
          end else if (r_buf[r_idx] != r_exp[r_idx]) begin
            r_success  <= 1'b0;
            r_mismatch <= r_idx;
            r_state    <= DONE;
          end else if (r_idx == AW'(NExpected - 1)) begin
            r_success <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: r_finished <= 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Buffer and table are deliberately left out of reset
  always_ff @(posedge clock) begin
    if (w_accept) r_buf[r_wr_ptr] <= outData;
    if (expWrite && !start && (r_state == IDLE || r_state == DONE) && (int'(expAddr) < NExpected))
      r_exp[expAddr] <= expData;
  end

  assign outReady      = r_out_ready;
  assign finished      = r_finished;
  assign success       = r_success;
  assign outCount      = r_count;
  assign mismatchIndex = r_mismatch;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_out_channel_checker.sv
// tb/tb_out_channel_checker.sv - directed and randomized checks of out_channel_checker against a run-level model
module tb_out_channel_checker;
  localparam int NOUT = 100;
  localparam int NEXP = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        expWrite = 1'b0;
  logic [6:0]  expAddr = '0;
  logic [11:0] expData = '0;
  logic        outValid = 1'b0;
  logic [11:0] outData = '0;
  logic        outReady;
  logic        programFinished = 1'b0;
  logic        finished;
  logic        success;
  logic [6:0]  outCount;
  logic [6:0]  mismatchIndex;
  logic        overflow;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [11:0] exp_m [NEXP];
  logic [11:0] q [$];

  always #5 clk = ~clk;

  out_channel_checker #(.MemoryElementWidth(12), .NOut(NOUT), .NExpected(NEXP)) dut (
    .clock(clk), .reset(reset), .start(start), .expWrite(expWrite), .expAddr(expAddr),
    .expData(expData), .outValid(outValid), .outData(outData), .outReady(outReady),
    .programFinished(programFinished), .finished(finished), .success(success),
    .outCount(outCount), .mismatchIndex(mismatchIndex), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Run outcome from the rules: exact-length list equal to the table passes,
  // wrong length or overflow fails at once, otherwise the first differing index fails.
  function automatic void model(input logic [11:0] w[$], output bit s, output int mi,
                                output int lat, output int cnt, output bit ovf);
    cnt = (w.size() > NOUT) ? NOUT : w.size();
    ovf = w.size() > NOUT;
    if (ovf || w.size() != NEXP) begin
      s = 0; mi = (cnt < NEXP) ? cnt : NEXP - 1; lat = 2;
      return;
    end
    s = 1; mi = 0; lat = 1 + NEXP;
    for (int i = 0; i < NEXP; i++) begin
      if (w[i] != exp_m[i]) begin
        s = 0; mi = i; lat = 2 + i;
        break;
      end
    end
  endfunction

  task automatic load_exp(input logic [11:0] a, input logic [11:0] b);
    exp_m[0] = a; exp_m[1] = b;
    expWrite = 1'b1; expAddr = 7'd0; expData = a;
    @(negedge clk);
    expAddr = 7'd1; expData = b;
    @(negedge clk);
    expWrite = 1'b0;
  endtask

  task automatic do_run(input string tag, input logic [11:0] w[$], input bit fin_last, input bit poke_exp);
    bit s, ovf;
    int mi, lat, cnt, got;
    model(w, s, mi, lat, cnt, ovf);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "/ready"}, 32'(outReady), 32'd1);
    foreach (w[i]) begin
      if ($urandom_range(0, 2) == 0) begin
        outValid = 1'b0; outData = 12'($urandom);
        @(negedge clk);
      end
      outValid = 1'b1; outData = w[i];
      if (poke_exp) begin expWrite = 1'b1; expAddr = 7'd0; expData = ~exp_m[0]; end
      if (fin_last && i == w.size() - 1) programFinished = 1'b1;
      @(negedge clk);
    end
    expWrite = 1'b0;
    if (!(fin_last && w.size() > 0)) begin
      outValid = 1'b0; programFinished = 1'b1;
      @(negedge clk);
    end
    programFinished = 1'b0;
    outValid = 1'b1; outData = 12'($urandom);
    chk({tag, "/ready_in_check"}, 32'(outReady), 32'd0);
    got = 0;
    while (finished !== 1'b1 && got < 200) begin
      @(negedge clk);
      got++;
    end
    outValid = 1'b0;
    chk({tag, "/latency"}, 32'(got), 32'(lat));
    chk({tag, "/success"}, 32'(success), 32'(s));
    chk({tag, "/count"}, 32'(outCount), 32'(cnt));
    chk({tag, "/overflow"}, 32'(overflow), 32'(ovf));
    if (!s) chk({tag, "/mismatch_index"}, 32'(mismatchIndex), 32'(mi));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst/ready", 32'(outReady), 32'd0);
    chk("rst/finished", 32'(finished), 32'd0);
    chk("rst/success", 32'(success), 32'd0);
    chk("rst/count", 32'(outCount), 32'd0);
    chk("rst/overflow", 32'(overflow), 32'd0);
    chk("rst/mismatch", 32'(mismatchIndex), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle/ready", 32'(outReady), 32'd0);

    load_exp(12'd3, 12'd5);
    q = '{12'd3, 12'd5};  do_run("match", q, 1'b0, 1'b0);
    q = '{12'd3, 12'd6};  do_run("mis1", q, 1'b0, 1'b0);
    q = '{12'd7, 12'd5};  do_run("mis0", q, 1'b0, 1'b0);
    q = '{12'd3};         do_run("short", q, 1'b0, 1'b0);
    q = '{12'd3, 12'd5};  do_run("fin_with_last", q, 1'b1, 1'b1);
    q.delete();           do_run("empty", q, 1'b0, 1'b0);
    q = '{12'd3, 12'd5, 12'd9}; do_run("long", q, 1'b0, 1'b0);

    q.delete();
    for (int i = 0; i <= NOUT; i++) q.push_back(12'($urandom));
    do_run("overflow", q, 1'b0, 1'b0);
    chk("overflow/wrap_slot0", 32'(dut.r_buf[0]), 32'(q[NOUT]));

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    outValid = 1'b1; outData = 12'd3;
    @(negedge clk); outData = 12'd5; programFinished = 1'b1;
    @(negedge clk); outValid = 1'b0; programFinished = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst/ready", 32'(outReady), 32'd0);
    chk("async_rst/finished", 32'(finished), 32'd0);
    chk("async_rst/success", 32'(success), 32'd0);
    chk("async_rst/count", 32'(outCount), 32'd0);
    chk("async_rst/overflow", 32'(overflow), 32'd0);
    @(negedge clk); reset = 1'b0;
    q = '{12'd3, 12'd5};  do_run("after_rst", q, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int len;
      load_exp(12'($urandom), 12'($urandom));
      len = $urandom_range(0, 3);
      q.delete();
      for (int i = 0; i < len; i++)
        q.push_back((i < NEXP && $urandom_range(0, 3) != 0) ? exp_m[i] : 12'($urandom));
      do_run($sformatf("rand%0d", r), q, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
